io_uart_tx: RTL and testbench
=============================

# io_uart_tx

Byte-wide UART transmitter peripheral on the IO side of the core, directly downstream of the IO address decoder. It consumes the decoder's registered write strobe and data byte, buffers bytes in a small FIFO, and serialises them 8N1 on a single TX line. Status outputs feed the decoder's read-back mux.

## Interface

Parameters:
- CLK_DIV, 434: clock cycles per UART bit. Minimum 2. Default gives 115200 baud at 50 MHz.
- FIFO_AW, 2: FIFO address width. Depth is 2**FIFO_AW (default 4).

Ports:
- CLK  in  1  system clock; all state changes on the rising edge
- RESET  in  1  asynchronous, active-high reset
- TX_WE  in  1  write strobe from the IO decoder, one byte per high cycle
- TX_WD  in  8  byte to transmit, sampled when TX_WE is high
- OVF_CLR  in  1  clears the sticky overflow flag
- TX  out  1  serial line, idle high
- BUSY  out  1  serialiser not in IDLE
- EMPTY  out  1  FIFO holds no bytes
- FULL  out  1  FIFO holds 2**FIFO_AW bytes
- LEVEL  out  FIFO_AW+1  number of bytes in the FIFO
- OVF  out  1  sticky flag: a write was dropped

## Operation

- FIFO: circular buffer with FIFO_AW-bit read/write pointers and a FIFO_AW+1 bit count. Pointers wrap modulo depth.
- Write acceptance: TX_WE high is accepted if FULL=0, or if a pop occurs in the same cycle.
  - Accepted write: store TX_WD at the write pointer and advance the pointer.
  - Rejected write: drop the byte and set OVF.
- LEVEL arithmetic: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
- OVF: stays set until OVF_CLR. If a dropped write and OVF_CLR occur in the same cycle, the set wins.
- Serialiser FSM states and line values:
  - IDLE: TX=1.
  - START: TX=0.
  - DATA: TX=current bit, LSB first, 8 bits.
  - STOP: TX=1.
- Bit timing: a baud counter loads CLK_DIV-1 on entry to each bit and counts down. The bit ends when the counter reaches 0. Each bit lasts exactly CLK_DIV cycles.
- IDLE -> START: when EMPTY=0. The head byte is popped into the shift register on that same edge.
- START -> DATA: at the end of the start bit, with the bit index set to 0.
- DATA: the shift register shifts right at each bit end. After bit index 7, go to STOP.
- STOP, at bit end:
  - EMPTY=0: pop the next byte and go straight to START. No idle gap.
  - EMPTY=1: go to IDLE.
- TX, BUSY, EMPTY, FULL, LEVEL and OVF are all registered or decoded from registered state. No combinational path from TX_WE to any output.

## Timing

- Reset values: TX=1, BUSY=0, EMPTY=1, FULL=0, LEVEL=0, OVF=0. FSM in IDLE, pointers 0, counter 0.
- RESET asserted mid-frame: TX returns to 1 asynchronously, the frame is aborted, and FIFO contents are discarded.
- Write latency: TX_WE high at edge k gives LEVEL/EMPTY updated after edge k.
- Start latency: with the FSM idle, a write at edge k is popped at edge k+1. After edge k+1, TX=0 and BUSY=1, and LEVEL returns to 0.
- Frame length: 10*CLK_DIV cycles.
  - Start bit: after edge k+1 through edge k+1+CLK_DIV.
  - Data bit n: begins after edge k+1+(n+1)*CLK_DIV.
  - BUSY falls after edge k+1+10*CLK_DIV if the FIFO is empty.
- Back-to-back frames: the stop bit is immediately followed by the next start bit. Frames are contiguous at 10*CLK_DIV cycles each.
- Full boundary: FULL=1 exactly when LEVEL=2**FIFO_AW. A write while full is accepted only on a pop edge (IDLE->START or STOP->START).

## Test plan

- Reset: assert RESET asynchronously mid-cycle, with no clock edge -> all outputs at their reset values immediately. Releasing RESET changes nothing until a write arrives.
- Single byte: CLK_DIV=4, write 0x55 at edge 0 -> TX=0 for cycles 1-4, then bits 1,0,1,0,1,0,1,0 for 4 cycles each (cycles 5-36), TX=1 from cycle 37. BUSY falls after edge 41.
- Back-to-back: CLK_DIV=4, write 0x00, 0xFF, 0xA5 on consecutive edges -> three contiguous 40-cycle frames with no idle cycle between stop and start. EMPTY=1 after the third pop.
- Overflow: FIFO_AW=2, CLK_DIV=4, write 6 bytes on edges 0-5 -> the first byte is popped at edge 1, LEVEL reaches 4 (FULL=1) at edge 4, the sixth byte is dropped and OVF=1 after edge 5. The transmitted sequence is the first five bytes only.
- Overflow clear race: with FIFO full and OVF=0, assert TX_WE and OVF_CLR together -> OVF=1. OVF_CLR alone next cycle -> OVF=0.
- Reset mid-frame: assert RESET during data bit 3 with 2 bytes queued -> TX=1 and LEVEL=0 at once. After release the line stays idle with no residual transmission.

Source files
------------

// File: rtl/io_uart_tx_if.sv
// Decoder-facing bus of the UART transmitter: write strobe/data, overflow clear and status read-back.
interface io_uart_tx_if #(
  parameter int unsigned FIFO_AW = 2
);
  logic               TX_WE;
  logic [7:0]         TX_WD;
  logic               OVF_CLR;
  logic               TX;
  logic               BUSY;
  logic               EMPTY;
  logic               FULL;
  logic [FIFO_AW:0]   LEVEL;
  logic               OVF;

  modport master (
    output TX_WE, TX_WD, OVF_CLR,
    input  TX, BUSY, EMPTY, FULL, LEVEL, OVF
  );

  modport slave (
    input  TX_WE, TX_WD, OVF_CLR,
    output TX, BUSY, EMPTY, FULL, LEVEL, OVF
  );
endinterface

// File: rtl/io_uart_tx.sv
// 8N1 UART transmitter with a small byte FIFO fed by the IO decoder's write strobe.
// All status outputs and the TX line come straight from registers.
module io_uart_tx #(
  parameter int unsigned CLK_DIV = 434,
  parameter int unsigned FIFO_AW = 2
) (
  input  logic          CLK,
  input  logic          RESET,
  io_uart_tx_if.slave   bus
);

  localparam int unsigned DEPTH = 1 << FIFO_AW;
  localparam int unsigned LW    = FIFO_AW + 1;
  localparam int unsigned CNT_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] BAUD_LOAD = CNT_W'(CLK_DIV - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t               r_state;
  logic [CNT_W-1:0]     r_baud;
  logic [2:0]           r_bit;
  logic [7:0]           r_shift;
  logic                 r_tx;
  logic                 r_busy;

  logic [7:0]           r_mem [DEPTH];
  logic [FIFO_AW-1:0]   r_wptr;
  logic [FIFO_AW-1:0]   r_rptr;
  logic [LW-1:0]        r_level;
  logic                 r_empty;
  logic                 r_full;
  logic                 r_ovf;

  logic                 w_pop;
  logic                 w_push;
  logic [LW-1:0]        w_level_nxt;
  logic [7:0]           w_head;

  assign w_head = r_mem[r_rptr];

  // Pop happens on IDLE->START and STOP->START; a pop frees a slot for a same-cycle write.
  always_comb begin
    w_pop       = !r_empty && ((r_state == S_IDLE) ||
                               ((r_state == S_STOP) && (r_baud == '0)));
    w_push      = bus.TX_WE && (!r_full || w_pop);
    w_level_nxt = r_level;
    if (w_push && !w_pop)
      w_level_nxt = r_level + LW'(1);
    else if (!w_push && w_pop)
      w_level_nxt = r_level - LW'(1);
  end

  always_ff @(posedge CLK) begin
    if (w_push)
      r_mem[r_wptr] <= bus.TX_WD;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_empty <= 1'b1;
      r_full  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_push)
        r_wptr <= r_wptr + FIFO_AW'(1);
      if (w_pop)
        r_rptr <= r_rptr + FIFO_AW'(1);
      r_level <= w_level_nxt;
      r_empty <= (w_level_nxt == '0);
      r_full  <= (w_level_nxt == LW'(DEPTH));
      // A dropped write beats a simultaneous clear.
      if (bus.TX_WE && !w_push)
        r_ovf <= 1'b1;
      else if (bus.OVF_CLR)
        r_ovf <= 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state <= S_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!r_empty) begin
            r_state <= S_START;
            r_shift <= w_head;
            r_baud  <= BAUD_LOAD;
            r_tx    <= 1'b0;
            r_busy  <= 1'b1;
          end
        end
        S_START: begin
          if (r_baud == '0) begin
            r_state <= S_DATA;
            r_bit   <= '0;
            r_baud  <= BAUD_LOAD;
            r_tx    <= r_shift[0];
          end else begin
            r_baud  <= r_baud - CNT_W'(1);
          end
        end
        S_DATA: begin
          if (r_baud == '0) begin
            r_shift <= r_shift >> 1;
            r_baud  <= BAUD_LOAD;
            if (r_bit == 3'd7) begin
              r_state <= S_STOP;
              r_tx    <= 1'b1;
            end else begin
              r_bit   <= r_bit + 3'd1;
              r_tx    <= r_shift[1];
            end
          end else begin
            r_baud  <= r_baud - CNT_W'(1);
          end
        end
        S_STOP: begin
          if (r_baud == '0) begin
            if (!r_empty) begin
              r_state <= S_START;
              r_shift <= w_head;
              r_baud  <= BAUD_LOAD;
              r_tx    <= 1'b0;
            end else begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_baud  <= r_baud - CNT_W'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.TX    = r_tx;
  assign bus.BUSY  = r_busy;
  assign bus.EMPTY = r_empty;
  assign bus.FULL  = r_full;
  assign bus.LEVEL = r_level;
  assign bus.OVF   = r_ovf;

endmodule

// File: tb/tb_io_uart_tx.sv
// Directed bench for io_uart_tx: reset, single frame, back-to-back frames, overflow and mid-frame reset.
module tb_io_uart_tx;

  localparam int unsigned CLK_DIV = 4;
  localparam int unsigned FIFO_AW = 2;
  localparam int          FRAME   = 10 * CLK_DIV;

  logic CLK;
  logic RESET;

  io_uart_tx_if #(.FIFO_AW(FIFO_AW)) bus ();

  io_uart_tx #(.CLK_DIV(CLK_DIV), .FIFO_AW(FIFO_AW)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc;
  int nf;
  logic [7:0] fb [8];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Expected line value after edge c, frames starting at edge 1 and packed back to back.
  function automatic logic exp_tx(input int c);
    int p;
    int f;
    logic [7:0] b;
    if (c < 1 || c > nf * FRAME) return 1'b1;
    p = (c - 1) % FRAME;
    f = (c - 1) / FRAME;
    b = fb[f];
    if (p < CLK_DIV) return 1'b0;
    if (p < 9 * CLK_DIV) return b[3'((p - CLK_DIV) / CLK_DIV)];
    return 1'b1;
  endfunction

  task automatic tick_chk();
    @(posedge CLK);
    #1;
    cyc++;
    check("tx", 32'(bus.TX), 32'(exp_tx(cyc)));
    check("busy", 32'(bus.BUSY), 32'((cyc >= 1 && cyc <= nf * FRAME) ? 1 : 0));
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_tx"},    32'(bus.TX),    32'd1);
    check({tag, "_busy"},  32'(bus.BUSY),  32'd0);
    check({tag, "_empty"}, 32'(bus.EMPTY), 32'd1);
    check({tag, "_full"},  32'(bus.FULL),  32'd0);
    check({tag, "_level"}, 32'(bus.LEVEL), 32'd0);
    check({tag, "_ovf"},   32'(bus.OVF),   32'd0);
  endtask

  initial begin
    logic [7:0] ob [6];
    logic [7:0] rb [3];
    ob = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    rb = '{8'hF0, 8'h5A, 8'h96};

    bus.TX_WE   = 1'b0;
    bus.TX_WD   = 8'h00;
    bus.OVF_CLR = 1'b0;
    cyc = -1000;
    nf  = 0;
    RESET = 1'b0;
    #3;
    RESET = 1'b1;
    #1;
    check_idle_outputs("rst_async");
    repeat (2) @(posedge CLK);
    #1;
    RESET = 1'b0;
    check_idle_outputs("rst_hold");
    repeat (5) tick_chk();
    check("rst_rel_level", 32'(bus.LEVEL), 32'd0);

    // Single byte 0x55.
    nf = 1; fb[0] = 8'h55; cyc = -1;
    bus.TX_WE = 1'b1; bus.TX_WD = 8'h55;
    tick_chk();
    bus.TX_WE = 1'b0;
    check("single_lvl_e0", 32'(bus.LEVEL), 32'd1);
    check("single_empty_e0", 32'(bus.EMPTY), 32'd0);
    tick_chk();
    check("single_lvl_e1", 32'(bus.LEVEL), 32'd0);
    check("single_empty_e1", 32'(bus.EMPTY), 32'd1);
    while (cyc < 45) tick_chk();

    // Three contiguous frames.
    nf = 3; fb[0] = 8'h00; fb[1] = 8'hFF; fb[2] = 8'hA5; cyc = -1;
    for (int i = 0; i < 3; i++) begin
      bus.TX_WE = 1'b1; bus.TX_WD = fb[i];
      tick_chk();
    end
    bus.TX_WE = 1'b0;
    check("b2b_lvl_e2", 32'(bus.LEVEL), 32'd2);
    while (cyc < 125) begin
      tick_chk();
      if (cyc == 80) check("b2b_empty_e80", 32'(bus.EMPTY), 32'd0);
      if (cyc == 81) begin
        check("b2b_empty_e81", 32'(bus.EMPTY), 32'd1);
        check("b2b_lvl_e81", 32'(bus.LEVEL), 32'd0);
      end
    end

    // Overflow: six writes into a four-deep FIFO, then the clear race.
    nf = 5; cyc = -1;
    for (int i = 0; i < 5; i++) fb[i] = ob[i];
    for (int i = 0; i < 6; i++) begin
      bus.TX_WE = 1'b1; bus.TX_WD = ob[i];
      tick_chk();
      check("ovf_level", 32'(bus.LEVEL), (i == 0) ? 32'd1 : (i >= 4 ? 32'd4 : 32'(i)));
      check("ovf_full", 32'(bus.FULL), (i >= 4) ? 32'd1 : 32'd0);
      check("ovf_flag", 32'(bus.OVF), (i == 5) ? 32'd1 : 32'd0);
    end
    bus.TX_WE = 1'b0; bus.OVF_CLR = 1'b1;
    tick_chk();
    check("ovf_clr", 32'(bus.OVF), 32'd0);
    bus.TX_WE = 1'b1; bus.TX_WD = 8'hEE;
    tick_chk();
    check("ovf_race", 32'(bus.OVF), 32'd1);
    check("ovf_race_level", 32'(bus.LEVEL), 32'd4);
    bus.TX_WE = 1'b0;
    tick_chk();
    check("ovf_clr2", 32'(bus.OVF), 32'd0);
    bus.OVF_CLR = 1'b0;
    while (cyc < 205) begin
      tick_chk();
      if (cyc == 41) check("ovf_lvl_e41", 32'(bus.LEVEL), 32'd3);
    end
    check("ovf_end_empty", 32'(bus.EMPTY), 32'd1);

    // Reset during data bit 3 of 0xF0 with two bytes queued.
    nf = 1; fb[0] = rb[0]; cyc = -1;
    for (int i = 0; i < 3; i++) begin
      bus.TX_WE = 1'b1; bus.TX_WD = rb[i];
      tick_chk();
    end
    bus.TX_WE = 1'b0;
    check("mid_lvl_e2", 32'(bus.LEVEL), 32'd2);
    while (cyc < 18) tick_chk();
    #3;
    RESET = 1'b1;
    #1;
    check_idle_outputs("mid_rst");
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    nf = 0;
    repeat (100) tick_chk();
    check("mid_post_level", 32'(bus.LEVEL), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
